// File: rtl/vec_alu_pkg.sv
// vec_alu_pkg: shared ALU opcodes, flag bit positions and sequencer states
package vec_alu_pkg;
  typedef enum logic [3:0] {
    ADD = 4'd0, SUB = 4'd1, AND = 4'd2, OR = 4'd3, NOR = 4'd4, XOR = 4'd5,
    SLL = 4'd6, SRL = 4'd7, SRA = 4'd8, ROL = 4'd9, ROR = 4'd10
  } alu_op_e;
  localparam logic [3:0] OP_MAX = 4'd10;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} seq_state_e;
endpackage

// File: rtl/alu.sv
// alu: combinational N-bit ALU; shifts/rotates take the amount on a and the value on b
module alu
  import vec_alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   ctrl,
  output logic [N-1:0] y,
  output logic [3:0]   flags
);
  localparam int SW = $clog2(N);
  logic [N:0] sum;
  logic [SW-1:0] sh;
  logic c, v;
  assign sh = a[SW-1:0];
  always_comb begin
    sum = '0;
    y = '0;
    c = 1'b0;
    v = 1'b0;
    case (ctrl)
      ADD: begin
        sum = {1'b0, a} + {1'b0, b};
        y = sum[N-1:0];
        c = sum[N];
        v = (a[N-1] == b[N-1]) && (y[N-1] != a[N-1]);
      end
      SUB: begin
        // carry out of a + ~b + 1 is the no-borrow flag
        sum = {1'b0, a} + {1'b0, ~b} + (N+1)'(1);
        y = sum[N-1:0];
        c = sum[N];
        v = (a[N-1] != b[N-1]) && (y[N-1] != a[N-1]);
      end
      AND: y = a & b;
      OR:  y = a | b;
      NOR: y = ~(a | b);
      XOR: y = a ^ b;
      SLL: y = b << sh;
      SRL: y = b >> sh;
      SRA: y = N'($signed(b) >>> sh);
      ROL: y = (b << sh) | (b >> (N - int'(sh)));
      ROR: y = (b >> sh) | (b << (N - int'(sh)));
      default: y = '0;
    endcase
  end
  assign flags = {y[N-1], y == '0, c, v};
endmodule

// File: rtl/vec_alu_sequencer.sv
// vec_alu_sequencer: issues a vector op one lane per cycle to an external ALU and assembles the result
module vec_alu_sequencer
  import vec_alu_pkg::*;
#(
  parameter int N = 8,
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_op,
  input  logic               in_scalar_b,
  input  logic [LANES*N-1:0] in_a,
  input  logic [LANES*N-1:0] in_b,
  output logic [N-1:0]       alu_a,
  output logic [N-1:0]       alu_b,
  output logic [3:0]         alu_ctrl,
  input  logic [N-1:0]       alu_y,
  input  logic [3:0]         alu_flags,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*N-1:0] out_y,
  output logic [LANES*4-1:0] out_flags,
  output logic               out_zero_all,
  output logic               out_err
);
  localparam int CW = $clog2(LANES);
  seq_state_e state, state_n;
  logic [CW-1:0] cnt;
  logic [3:0] op;
  logic [LANES*N-1:0] a_r, b_r, y_r, b_exp;
  logic [LANES*4-1:0] f_r;
  logic [LANES-1:0] z;
  logic err;
  always_comb begin
    b_exp = '0;
    for (int k = 0; k < LANES; k++) b_exp[k*N +: N] = in_scalar_b ? in_b[N-1:0] : in_b[k*N +: N];
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid) state_n = (in_op > OP_MAX) ? DONE : ISSUE;
      ISSUE:   if (cnt == CW'(LANES-1)) state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {cnt, op, a_r, b_r, y_r, f_r, err} <= '0;
    end else if (state == IDLE && in_valid) begin
      op <= in_op;
      a_r <= in_a;
      b_r <= b_exp;
      y_r <= '0;
      f_r <= '0;
      cnt <= '0;
      err <= in_op > OP_MAX;
    end else if (state == ISSUE) begin
      y_r[cnt*N +: N] <= alu_y;
      f_r[cnt*4 +: 4] <= alu_flags;
      cnt <= cnt + 1'b1;
    end
  end
  for (genvar i = 0; i < LANES; i++) begin : g_z
    assign z[i] = f_r[i*4 + FLAG_Z];
  end
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign out_y = y_r;
  assign out_flags = f_r;
  assign out_err = err;
  assign out_zero_all = out_valid & ~err & (&z);
  assign alu_a = (state == ISSUE) ? a_r[cnt*N +: N] : '0;
  assign alu_b = (state == ISSUE) ? b_r[cnt*N +: N] : '0;
  assign alu_ctrl = (state == ISSUE) ? op : '0;
endmodule

// File: tb/tb_vec_alu_sequencer.sv
// tb_vec_alu_sequencer: directed checks of the sequencer wired to alu #(8)
module tb_vec_alu_sequencer;
  import vec_alu_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_scalar_b = 1'b0, out_ready = 1'b0;
  logic [3:0] in_op = '0;
  logic [31:0] in_a = '0, in_b = '0;
  logic in_ready, out_valid, out_zero_all, out_err;
  logic [7:0] alu_a, alu_b, alu_y;
  logic [3:0] alu_ctrl, alu_flags;
  logic [31:0] out_y;
  logic [15:0] out_flags;
  int tests = 0, fails = 0;

  vec_alu_sequencer #(.N(8), .LANES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_scalar_b(in_scalar_b), .in_a(in_a), .in_b(in_b), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ctrl(alu_ctrl), .alu_y(alu_y), .alu_flags(alu_flags), .out_valid(out_valid),
    .out_ready(out_ready), .out_y(out_y), .out_flags(out_flags),
    .out_zero_all(out_zero_all), .out_err(out_err)
  );
  alu #(.N(8)) u_alu (.a(alu_a), .b(alu_b), .ctrl(alu_ctrl), .y(alu_y), .flags(alu_flags));

  always #5 clk = ~clk;

  task automatic send(input logic [3:0] op, input logic sc, input logic [31:0] a, input logic [31:0] b);
    in_op = op;
    in_scalar_b = sc;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int k);
    k = 1;
    while (!out_valid && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  task automatic consume;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid); end
    tests++; if (out_y !== 32'h0 || out_flags !== 16'h0 || out_zero_all !== 1'b0 || out_err !== 1'b0) begin fails++; $display("FAIL reset_out: y=%h f=%h za=%b err=%b want zeros", out_y, out_flags, out_zero_all, out_err); end
    tests++; if ({alu_a, alu_b, alu_ctrl} !== 20'h0) begin fails++; $display("FAIL reset_alu: a=%h b=%h ctrl=%h want 0", alu_a, alu_b, alu_ctrl); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_add;
    int k;
    send(ADD, 1'b0, 32'h047F0002, 32'h04040002);
    tests++; if (alu_ctrl !== 4'd0 || alu_a !== 8'd2 || alu_b !== 8'd2) begin fails++; $display("FAIL add_lane0_drive: a=%h b=%h ctrl=%h want 02 02 0", alu_a, alu_b, alu_ctrl); end
    wait_valid(k);
    tests++; if (k !== 5) begin fails++; $display("FAIL add_latency: got %0d want 5", k); end
    tests++; if (out_y !== 32'h08830004) begin fails++; $display("FAIL add_y: got %h want 08830004", out_y); end
    tests++; if (out_flags !== 16'h0940) begin fails++; $display("FAIL add_flags: got %h want 0940", out_flags); end
    tests++; if (out_zero_all !== 1'b0 || out_err !== 1'b0 || in_ready !== 1'b0) begin fails++; $display("FAIL add_misc: za=%b err=%b in_ready=%b want 0 0 0", out_zero_all, out_err, in_ready); end
    tests++; if ({alu_a, alu_b, alu_ctrl} !== 20'h0) begin fails++; $display("FAIL add_alu_done: a=%h b=%h ctrl=%h want 0", alu_a, alu_b, alu_ctrl); end
    consume;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL add_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_sub_scalar;
    int k;
    send(SUB, 1'b1, 32'h05070200, 32'hAABBCC05);
    wait_valid(k);
    tests++; if (k !== 5) begin fails++; $display("FAIL sub_latency: got %0d want 5", k); end
    tests++; if (out_y !== 32'h0002FDFB) begin fails++; $display("FAIL sub_y: got %h want 0002fdfb", out_y); end
    tests++; if (out_flags !== 16'h6288) begin fails++; $display("FAIL sub_flags: got %h want 6288", out_flags); end
    consume;
  endtask

  task automatic test_shift;
    int k;
    send(SLL, 1'b0, 32'h01020300, 32'h810F01FF);
    wait_valid(k);
    tests++; if (out_y !== 32'h023C08FF || out_flags !== 16'h0008) begin fails++; $display("FAIL sll: y=%h f=%h want 023c08ff 0008", out_y, out_flags); end
    consume;
  endtask

  task automatic test_illegal;
    int k;
    send(4'd12, 1'b0, 32'h11223344, 32'h55667788);
    tests++; if (alu_ctrl !== 4'd0) begin fails++; $display("FAIL ill_ctrl: got %0d want 0", alu_ctrl); end
    wait_valid(k);
    tests++; if (k !== 1) begin fails++; $display("FAIL ill_latency: got %0d want 1", k); end
    tests++; if (out_err !== 1'b1 || out_y !== 32'h0 || out_flags !== 16'h0 || out_zero_all !== 1'b0) begin fails++; $display("FAIL ill_out: err=%b y=%h f=%h za=%b want 1 0 0 0", out_err, out_y, out_flags, out_zero_all); end
    repeat (3) begin
      @(posedge clk);
      #1;
      tests++; if (alu_ctrl !== 4'd0 || out_valid !== 1'b1) begin fails++; $display("FAIL ill_hold: ctrl=%0d out_valid=%b want 0 1", alu_ctrl, out_valid); end
    end
    consume;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL ill_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_backpressure;
    int k;
    send(ADD, 1'b0, 32'h047F0002, 32'h04040002);
    wait_valid(k);
    in_op = XOR;
    in_a = 32'hFFFFFFFF;
    in_b = 32'h0;
    in_valid = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      tests++; if (out_y !== 32'h08830004 || out_valid !== 1'b1 || in_ready !== 1'b0) begin fails++; $display("FAIL bp_hold%0d: y=%h v=%b rdy=%b want 08830004 1 0", i, out_y, out_valid, in_ready); end
    end
    in_valid = 1'b0;
    consume;
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL bp_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid); end
  endtask

  task automatic test_reset_mid;
    int k;
    send(ADD, 1'b0, 32'h047F0002, 32'h04040002);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_y !== 32'h0 || alu_ctrl !== 4'd0) begin fails++; $display("FAIL rstmid: v=%b rdy=%b y=%h ctrl=%h want 0 1 0 0", out_valid, in_ready, out_y, alu_ctrl); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(SUB, 1'b1, 32'h05070200, 32'h00000005);
    wait_valid(k);
    tests++; if (k !== 5 || out_y !== 32'h0002FDFB || out_flags !== 16'h6288) begin fails++; $display("FAIL rstmid_next: k=%0d y=%h f=%h want 5 0002fdfb 6288", k, out_y, out_flags); end
    consume;
  endtask

  task automatic test_zero;
    int k;
    send(XOR, 1'b0, 32'h010500C8, 32'h010500C8);
    wait_valid(k);
    tests++; if (out_y !== 32'h0 || out_zero_all !== 1'b1 || out_flags !== 16'h4444) begin fails++; $display("FAIL zero: y=%h za=%b f=%h want 0 1 4444", out_y, out_zero_all, out_flags); end
    consume;
  endtask

  task automatic test_back_to_back;
    int n = 0;
    in_op = ADD;
    in_scalar_b = 1'b0;
    in_a = 32'h047F0002;
    in_b = 32'h04040002;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        n++;
        tests++; if (out_y !== 32'h08830004) begin fails++; $display("FAIL b2b_y: got %h want 08830004", out_y); end
      end
    end
    tests++; if (n !== 4) begin fails++; $display("FAIL b2b_count: got %0d want 4", n); end
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub_scalar;
    test_shift;
    test_illegal;
    test_backpressure;
    test_reset_mid;
    test_zero;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
